// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and word type.
package y86_pkg;

  typedef logic [63:0] word_t;
  typedef logic [3:0]  regid_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam regid_t R_RSP  = 4'h4;
  localparam regid_t R_NONE = 4'hF;

  function automatic logic is_real_reg(regid_t id);
    return id != R_NONE;
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// 15 x 64 program register array: two async read ports, debug read port,
// and two write ports where M overrides E on the same destination.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val
);

  word_t regs_q [0:14];
  word_t regs_d [0:14];

  // M port is applied last so it wins a collision with E.
  always_comb begin
    for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
    if (we_e && is_real_reg(dst_e)) regs_d[dst_e] = val_e;
    if (we_m && is_real_reg(dst_m)) regs_d[dst_m] = val_m;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
    end else begin
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign val_a   = is_real_reg(src_a)   ? regs_q[src_a]   : 64'h0;
  assign val_b   = is_real_reg(src_b)   ? regs_q[src_b]   : 64'h0;
  assign dbg_val = is_real_reg(dbg_sel) ? regs_q[dbg_sel] : 64'h0;

endmodule

// File: rtl/decode_regfile.sv
// SEQ decode stage: derives source/destination register IDs from the
// instruction fields and owns the architectural register file.
module decode_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val
);

  always_comb begin
    srcA = R_NONE;
    srcB = R_NONE;
    dstE = R_NONE;
    dstM = R_NONE;
    case (icode)
      I_RRMOVQ: begin
        srcA = rA;
        if (cnd) dstE = rB;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_RET: begin
        srcA = R_RSP;
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_POPQ: begin
        srcA = R_RSP;
        srcB = R_RSP;
        dstE = R_RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  regfile_2r2w #(
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_e    (en),
    .dst_e   (dstE),
    .val_e   (valE),
    .we_m    (en),
    .dst_m   (dstM),
    .val_m   (valM),
    .src_a   (srcA),
    .src_b   (srcB),
    .val_a   (valA),
    .val_b   (valB),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

endmodule

// File: tb/tb_decode_regfile.sv
// Directed-vector bench for decode_regfile with hand-computed expectations.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_regfile #(
    .RSP_INIT (64'h200)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .icode   (icode),
    .rA      (rA),
    .rB      (rB),
    .cnd     (cnd),
    .valE    (valE),
    .valM    (valM),
    .srcA    (srcA),
    .srcB    (srcB),
    .dstE    (dstE),
    .dstM    (dstM),
    .valA    (valA),
    .valB    (valB),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] sel, input string tag, input logic [63:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, dbg_val, exp);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dbg_sel = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    step();
    step();
    rst = 1'b0;

    peek(4'h4, "rst_rsp", 64'h200);
    peek(4'h0, "rst_r0", 64'h0);
    peek(4'hF, "rst_rnone", 64'h0);

    // irmovq $0x10, %rdx
    en = 1'b1;
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h10, 64'h0);
    chk("irmovq_dstE", 64'(dstE), 64'h2);
    chk("irmovq_srcA", 64'(srcA), 64'hF);
    step();
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    peek(4'h2, "irmovq_r2", 64'h10);

    // OPq %rdx, %rbx
    drive(4'h6, 4'h2, 4'h3, 1'b0, 64'h33, 64'h0);
    chk("opq_srcA", 64'(srcA), 64'h2);
    chk("opq_srcB", 64'(srcB), 64'h3);
    chk("opq_valA", valA, 64'h10);
    chk("opq_valB", valB, 64'h0);
    chk("opq_dstE", 64'(dstE), 64'h3);
    step();
    peek(4'h3, "opq_r3", 64'h33);

    // cmovXX not taken then taken
    drive(4'h2, 4'h1, 4'h5, 1'b0, 64'hDEAD, 64'h0);
    chk("cmov0_dstE", 64'(dstE), 64'hF);
    chk("cmov0_srcA", 64'(srcA), 64'h1);
    step();
    peek(4'h5, "cmov0_r5", 64'h0);
    drive(4'h2, 4'h1, 4'h5, 1'b1, 64'hDEAD, 64'h0);
    chk("cmov1_dstE", 64'(dstE), 64'h5);
    step();
    peek(4'h5, "cmov1_r5", 64'hDEAD);

    // popq %rsp: M beats E on the same destination; reads see old value
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'h77);
    chk("popq_srcA", 64'(srcA), 64'h4);
    chk("popq_srcB", 64'(srcB), 64'h4);
    chk("popq_dstE", 64'(dstE), 64'h4);
    chk("popq_dstM", 64'(dstM), 64'h4);
    chk("popq_valA_old", valA, 64'h200);
    step();
    peek(4'h4, "popq_rsp", 64'h77);

    // mrmovq into %rsi, then the same with en low
    drive(4'h5, 4'h6, 4'h4, 1'b0, 64'h0, 64'h66);
    chk("mrmovq_dstM", 64'(dstM), 64'h6);
    chk("mrmovq_srcB", 64'(srcB), 64'h4);
    step();
    peek(4'h6, "mrmovq_r6", 64'h66);
    en = 1'b0;
    drive(4'h5, 4'h6, 4'hF, 1'b0, 64'h0, 64'h5);
    step();
    step();
    peek(4'h6, "stall_r6", 64'h66);
    chk("stall_valB_live", valB, 64'h0);

    // reset wins over a pending write
    en = 1'b1; rst = 1'b1;
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h99, 64'h0);
    step();
    rst = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    peek(4'h6, "rstpri_r6", 64'h0);
    peek(4'h4, "rstpri_rsp", 64'h200);
    peek(4'h5, "rstpri_r5", 64'h0);

    // irmovq to RNONE changes nothing
    drive(4'h3, 4'hF, 4'hF, 1'b0, 64'h1, 64'h0);
    step();
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), $sformatf("rnone_r%0d", i), (i == 4) ? 64'h200 : 64'h0);
    end

    // unknown icode with a populated source register
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h22, 64'h0);
    step();
    drive(4'hE, 4'h2, 4'h4, 1'b1, 64'h5, 64'h6);
    chk("unk_srcA", 64'(srcA), 64'hF);
    chk("unk_srcB", 64'(srcB), 64'hF);
    chk("unk_dstE", 64'(dstE), 64'hF);
    chk("unk_dstM", 64'(dstM), 64'hF);
    chk("unk_valA", valA, 64'h0);
    chk("unk_valB", valB, 64'h0);
    step();
    peek(4'h2, "unk_r2", 64'h22);
    peek(4'h4, "unk_rsp", 64'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
